iomem_arbiter: RTL

IOMEM_ARBITER -- requirements
Module: iomem_arbiter

---
 rtl/iomem_arb_pkg.sv | 18 +
 rtl/iomem_arb_rr2.sv | 40 ++++
 rtl/iomem_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/iomem_arb_pkg.sv
// -----------------------------------------------------------------------------
// iomem_arb_pkg
// Shared definitions for the two-requester iomem arbiter.
//   arb_state_t : arbiter FSM states (IDLE, GRANT0, GRANT1, GAP)
//   ERR_RDATA   : read data returned to a requester whose access was aborted
// -----------------------------------------------------------------------------
package iomem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GRANT0 = 2'd1,
      ST_GRANT1 = 2'd2,
      ST_GAP    = 2'd3
   } arb_state_t;

   localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/iomem_arb_rr2.sv
// -----------------------------------------------------------------------------
// iomem_arb_rr2
// Two-way round-robin selector. On a tie the requester not granted last wins.
// Ports:
//   clk_i   : clock
//   rst_n   : synchronous active-low reset (m0 wins the first tie)
//   i_req   : request vector, bit N = requester N
//   i_take  : a grant is being issued this cycle; remember the winner
//   o_sel   : selected requester (0 or 1), valid whenever i_req != 0
// -----------------------------------------------------------------------------
module iomem_arb_rr2 (
   input  logic       clk_i,
   input  logic       rst_n,
   input  logic [1:0] i_req,
   input  logic       i_take,
   output logic       o_sel
);

   // Index of the requester granted most recently.
   logic r_last;

   always_comb begin
      o_sel = 1'b0;
      if (i_req == 2'b11) begin
         o_sel = ~r_last;
      end else if (i_req == 2'b10) begin
         o_sel = 1'b1;
      end
   end

   // Reset points at m1 so that m0 wins the first tie.
   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         r_last <= 1'b1;
      end else if (i_take) begin
         r_last <= o_sel;
      end
   end

endmodule

// File: rtl/iomem_arbiter.sv
// -----------------------------------------------------------------------------
// iomem_arbiter
// Shares one iomem bus between two requesters (m0, m1) with round-robin
// arbitration. A grant holds the bus until iomem_ready_i, or until the granted
// requester withdraws; every grant is followed by one idle GAP cycle.
//
// Optional feature (macro IOMEM_ARB_TIMEOUT_EN): a grant that sees no
// iomem_ready_i for TIMEOUT_CYCLES cycles is aborted; the requester gets a
// ready pulse with ERR_RDATA and timeout_o pulses. Without the macro the
// arbiter waits indefinitely and timeout_o is tied low.
//
// Ports:
//   clk_i, rst_n               : clock, synchronous active-low reset
//   mN_valid_i / mN_ready_o    : requester N request / completion pulse
//   mN_wstrb_i/addr_i/wdata_i  : requester N access (wstrb == 0 is a read)
//   mN_rdata_o                 : requester N read data (0 when not granted)
//   iomem_*                    : shared bus, driven by the granted requester
//   busy_o                     : a grant is held
//   timeout_o                  : one-cycle abort pulse
// -----------------------------------------------------------------------------
module iomem_arbiter
   import iomem_arb_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk_i,
   input  logic              rst_n,
   input  logic              m0_valid_i,
   output logic              m0_ready_o,
   input  logic [3:0]        m0_wstrb_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_wdata_i,
   output logic [DATA_W-1:0] m0_rdata_o,
   input  logic              m1_valid_i,
   output logic              m1_ready_o,
   input  logic [3:0]        m1_wstrb_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [DATA_W-1:0] m1_wdata_i,
   output logic [DATA_W-1:0] m1_rdata_o,
   output logic              iomem_valid_o,
   input  logic              iomem_ready_i,
   output logic [3:0]        iomem_wstrb_o,
   output logic [ADDR_W-1:0] iomem_addr_o,
   output logic [DATA_W-1:0] iomem_wdata_o,
   input  logic [DATA_W-1:0] iomem_rdata_i,
   output logic              busy_o,
   output logic              timeout_o
);

   arb_state_t r_state;

   logic              w_g0;
   logic              w_g1;
   logic              w_grant;
   logic              w_own_valid;
   logic              w_take;
   logic              w_sel;
   logic              w_tmo;
   logic [DATA_W-1:0] w_resp_data;

   assign w_g0        = (r_state == ST_GRANT0);
   assign w_g1        = (r_state == ST_GRANT1);
   assign w_grant     = w_g0 | w_g1;
   assign w_own_valid = (w_g0 & m0_valid_i) | (w_g1 & m1_valid_i);
   assign w_take      = (r_state == ST_IDLE) & (m0_valid_i | m1_valid_i);

   iomem_arb_rr2 u_rr2 (
      .clk_i  (clk_i),
      .rst_n  (rst_n),
      .i_req  ({m1_valid_i, m0_valid_i}),
      .i_take (w_take),
      .o_sel  (w_sel)
   );

`ifdef IOMEM_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   // Counts completed grant cycles; equals TIMEOUT_CYCLES-1 during the last
   // permitted cycle, which is where the abort is signalled.
   logic [CNT_W-1:0] r_tmo_cnt;

   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         r_tmo_cnt <= '0;
      end else if (w_grant) begin
         r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end else begin
         r_tmo_cnt <= '0;
      end
   end

   assign w_tmo = w_own_valid & ~iomem_ready_i &
                  (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign w_tmo = 1'b0;
`endif

   assign timeout_o = w_tmo;

   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_take) begin
                  r_state <= w_sel ? ST_GRANT1 : ST_GRANT0;
               end
            end
            ST_GRANT0, ST_GRANT1: begin
               // Completion, withdrawal and abort all release the bus.
               if (iomem_ready_i || !w_own_valid || w_tmo) begin
                  r_state <= ST_GAP;
               end
            end
            ST_GAP:  r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy_o        = w_grant;
   assign iomem_valid_o = w_grant;

   always_comb begin
      iomem_wstrb_o = 4'b0000;
      iomem_addr_o  = '0;
      iomem_wdata_o = '0;
      if (w_g0) begin
         iomem_wstrb_o = m0_wstrb_i;
         iomem_addr_o  = m0_addr_i;
         iomem_wdata_o = m0_wdata_i;
      end else if (w_g1) begin
         iomem_wstrb_o = m1_wstrb_i;
         iomem_addr_o  = m1_addr_i;
         iomem_wdata_o = m1_wdata_i;
      end
   end

   assign w_resp_data = w_tmo ? DATA_W'(ERR_RDATA) : iomem_rdata_i;

   assign m0_ready_o = w_g0 & (iomem_ready_i | w_tmo);
   assign m1_ready_o = w_g1 & (iomem_ready_i | w_tmo);
   assign m0_rdata_o = w_g0 ? w_resp_data : '0;
   assign m1_rdata_o = w_g1 ? w_resp_data : '0;

endmodule
